// File: rtl/ec1_mem_arbiter.sv
// EC1 memory arbiter: serialises CPU and loader/debug ports onto one RAM.
// Round-robin or fixed-priority grant, registered RAM strobes.
module ec1_mem_arbiter #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 8,
    parameter bit RR_MODE = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              we0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              we1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t              state_q;
    logic                sel_q;
    logic                last_gnt_q;
    logic                ack0_q;
    logic                ack1_q;
    logic [DATA_W-1:0]   rdata0_q;
    logic [DATA_W-1:0]   rdata1_q;
    logic                mem_en_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;

    logic                sel_d;
    logic [ADDR_W-1:0]   win_addr;
    logic                win_we;
    logic [DATA_W-1:0]   win_wdata;

    // Pick the winner: a lone requester always wins, ties go by mode.
    always_comb begin
        sel_d = 1'b0;
        if (req0 && req1) begin
            sel_d = RR_MODE ? ~last_gnt_q : 1'b0;
        end else if (req1) begin
            sel_d = 1'b1;
        end
    end

    assign win_addr  = sel_d ? addr1  : addr0;
    assign win_we    = sel_d ? we1    : we0;
    assign win_wdata = sel_d ? wdata1 : wdata0;

    // Access sequencer: IDLE -> ISSUE -> WAIT -> ACK, all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            last_gnt_q  <= 1'b1;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        sel_q       <= sel_d;
                        mem_addr_q  <= win_addr;
                        mem_we_q    <= win_we;
                        mem_wdata_q <= win_wdata;
                        mem_en_q    <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    state_q  <= WAIT;
                end
                WAIT: begin
                    if (sel_q) begin
                        ack1_q   <= 1'b1;
                        rdata1_q <= mem_rdata;
                    end else begin
                        ack0_q   <= 1'b1;
                        rdata0_q <= mem_rdata;
                    end
                    state_q <= ACK;
                end
                ACK: begin
                    ack0_q     <= 1'b0;
                    ack1_q     <= 1'b0;
                    last_gnt_q <= sel_q;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ec1_mem_arbiter.sv
// Directed bench for ec1_mem_arbiter: one round-robin and one
// fixed-priority instance driven in lockstep, each with its own RAM.
module tb_ec1_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [4:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;

    logic       a_ack0, a_ack1, a_en, a_we, a_busy;
    logic [7:0] a_rd0, a_rd1, a_wd, a_mrd;
    logic [4:0] a_addr;
    logic       b_ack0, b_ack1, b_en, b_we, b_busy;
    logic [7:0] b_rd0, b_rd1, b_wd, b_mrd;
    logic [4:0] b_addr;

    logic       pre_we = 1'b0;
    logic [4:0] pre_addr = '0;
    logic [7:0] pre_data = '0;
    logic [7:0] ram_a [32];
    logic [7:0] ram_b [32];

    int n_chk = 0, n_pass = 0;
    int na0 = 0, na1 = 0, en_cnt = 0, we_cnt = 0;
    bit both_seen = 1'b0, b2b_seen = 1'b0;
    logic pa_en = 1'b0, pb_en = 1'b0;

    always #5 clk = ~clk;

    ec1_mem_arbiter #(.ADDR_W(5), .DATA_W(8), .RR_MODE(1'b1)) u_rr (
        .clk(clk), .reset(reset),
        .req0(req0), .addr0(addr0), .we0(we0), .wdata0(wdata0),
        .ack0(a_ack0), .rdata0(a_rd0),
        .req1(req1), .addr1(addr1), .we1(we1), .wdata1(wdata1),
        .ack1(a_ack1), .rdata1(a_rd1),
        .mem_en(a_en), .mem_we(a_we), .mem_addr(a_addr),
        .mem_wdata(a_wd), .mem_rdata(a_mrd), .busy(a_busy)
    );

    ec1_mem_arbiter #(.ADDR_W(5), .DATA_W(8), .RR_MODE(1'b0)) u_fp (
        .clk(clk), .reset(reset),
        .req0(req0), .addr0(addr0), .we0(we0), .wdata0(wdata0),
        .ack0(b_ack0), .rdata0(b_rd0),
        .req1(req1), .addr1(addr1), .we1(we1), .wdata1(wdata1),
        .ack1(b_ack1), .rdata1(b_rd1),
        .mem_en(b_en), .mem_we(b_we), .mem_addr(b_addr),
        .mem_wdata(b_wd), .mem_rdata(b_mrd), .busy(b_busy)
    );

    // Synchronous RAM models: read data valid one cycle after the strobe.
    always @(posedge clk) begin
        if (pre_we) begin
            ram_a[pre_addr] <= pre_data;
        end else if (a_en) begin
            if (a_we) ram_a[a_addr] <= a_wd;
            a_mrd <= ram_a[a_addr];
        end
    end

    always @(posedge clk) begin
        if (pre_we) begin
            ram_b[pre_addr] <= pre_data;
        end else if (b_en) begin
            if (b_we) ram_b[b_addr] <= b_wd;
            b_mrd <= ram_b[b_addr];
        end
    end

    // Cycle monitor: ack counts, strobe counts, invariants.
    always @(negedge clk) begin
        if (a_ack0) na0++;
        if (a_ack1) na1++;
        if (a_en) en_cnt++;
        if (a_we) we_cnt++;
        if ((a_ack0 && a_ack1) || (b_ack0 && b_ack1)) both_seen = 1'b1;
        if ((a_en && pa_en) || (b_en && pb_en)) b2b_seen = 1'b1;
        pa_en = a_en;
        pb_en = b_en;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One complete access on instance A, checked cycle by cycle.
    task automatic do_access(input bit p, input logic [4:0] a, input bit w,
                             input logic [7:0] d, input logic [7:0] exp_rd);
        if (!p) begin
            req0 = 1'b1; addr0 = a; we0 = w; wdata0 = d;
        end else begin
            req1 = 1'b1; addr1 = a; we1 = w; wdata1 = d;
        end
        @(negedge clk);
        chk("issue_en", 32'(a_en), 1);
        chk("issue_addr", 32'(a_addr), 32'(a));
        chk("issue_we", 32'(a_we), 32'(w));
        if (w) chk("issue_wdata", 32'(a_wd), 32'(d));
        chk("issue_busy", 32'(a_busy), 1);
        @(negedge clk);
        chk("wait_en", 32'(a_en), 0);
        chk("wait_we", 32'(a_we), 0);
        @(negedge clk);
        chk("ack", 32'(p ? a_ack1 : a_ack0), 1);
        chk("ack_other", 32'(p ? a_ack0 : a_ack1), 0);
        if (!w) chk("rdata", 32'(p ? a_rd1 : a_rd0), 32'(exp_rd));
        if (!p) req0 = 1'b0;
        else req1 = 1'b0;
        @(negedge clk);
        chk("ack_drop", 32'(p ? a_ack1 : a_ack0), 0);
        chk("idle_busy", 32'(a_busy), 0);
    endtask

    initial begin
        int w0, c0, c1;

        // Reset held two cycles; RAM preloaded meanwhile.
        @(negedge clk);
        pre_we = 1'b1; pre_addr = 5'd5; pre_data = 8'hA3;
        @(negedge clk);
        pre_we = 1'b0;
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_ack0", 32'(a_ack0), 0);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("post_ack0", 32'(a_ack0), 0);
        chk("post_ack1", 32'(a_ack1), 0);
        chk("post_rd0", 32'(a_rd0), 0);
        chk("post_rd1", 32'(a_rd1), 0);
        chk("post_en", 32'(a_en), 0);
        chk("post_we", 32'(a_we), 0);
        chk("post_addr", 32'(a_addr), 0);
        chk("post_wdata", 32'(a_wd), 0);
        chk("post_busy", 32'(a_busy), 0);
        chk("post_en_cnt", 32'(en_cnt), 0);

        // Port 0 reads RAM[5].
        do_access(1'b0, 5'd5, 1'b0, 8'h00, 8'hA3);

        // Port 1 writes 31, then port 0 reads it back.
        w0 = we_cnt;
        do_access(1'b1, 5'd31, 1'b1, 8'h5C, 8'h00);
        chk("we_pulse", 32'(we_cnt - w0), 1);
        chk("rd0_hold", 32'(a_rd0), 32'hA3);
        do_access(1'b0, 5'd31, 1'b0, 8'h00, 8'h5C);

        // Both ports held high from a fresh reset.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req0 = 1'b1; addr0 = 5'd5; we0 = 1'b0;
        req1 = 1'b1; addr1 = 5'd31; we1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            @(negedge clk);
            @(negedge clk);
            chk("rr_ack0", 32'(a_ack0), (k % 2 == 0) ? 1 : 0);
            chk("rr_ack1", 32'(a_ack1), (k % 2 == 1) ? 1 : 0);
            if (k % 2 == 0) chk("rr_rd0", 32'(a_rd0), 32'hA3);
            else chk("rr_rd1", 32'(a_rd1), 32'h5C);
            chk("fp_ack0", 32'(b_ack0), 1);
            chk("fp_ack1", 32'(b_ack1), 0);
            if (k == 3) req0 = 1'b0;
            @(negedge clk);
        end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("fp_late_ack1", 32'(b_ack1), 1);
        chk("fp_late_rd1", 32'(b_rd1), 32'h5C);
        chk("rr_late_ack1", 32'(a_ack1), 1);
        req1 = 1'b0;
        @(negedge clk);

        // Reset lands while the access sits in WAIT.
        c0 = na0;
        req0 = 1'b1; addr0 = 5'd5; we0 = 1'b0;
        @(negedge clk);
        chk("r5_issue", 32'(a_en), 1);
        @(negedge clk);
        chk("r5_wait_busy", 32'(a_busy), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("r5_no_ack", 32'(a_ack0), 0);
        chk("r5_idle", 32'(a_busy), 0);
        chk("r5_en", 32'(a_en), 0);
        reset = 1'b0;
        do_access(1'b0, 5'd5, 1'b0, 8'h00, 8'hA3);
        chk("r5_ack_cnt", 32'(na0 - c0), 1);

        // req1 rises during port 0's ACK cycle.
        c0 = na0;
        c1 = na1;
        req0 = 1'b1; addr0 = 5'd0; we0 = 1'b1; wdata0 = 8'h11;
        @(negedge clk);
        chk("t6_issue0", 32'(a_en), 1);
        @(negedge clk);
        @(negedge clk);
        chk("t6_ack0", 32'(a_ack0), 1);
        req0 = 1'b0;
        req1 = 1'b1; addr1 = 5'd0; we1 = 1'b0;
        @(negedge clk);
        chk("t6_ack0_drop", 32'(a_ack0), 0);
        chk("t6_idle", 32'(a_busy), 0);
        chk("t6_no_en", 32'(a_en), 0);
        @(negedge clk);
        chk("t6_issue1", 32'(a_en), 1);
        chk("t6_addr1", 32'(a_addr), 0);
        @(negedge clk);
        @(negedge clk);
        chk("t6_ack1", 32'(a_ack1), 1);
        chk("t6_rd1", 32'(a_rd1), 32'h11);
        req1 = 1'b0;
        @(negedge clk);
        chk("t6_ack1_drop", 32'(a_ack1), 0);
        chk("t6_cnt0", 32'(na0 - c0), 1);
        chk("t6_cnt1", 32'(na1 - c1), 1);

        chk("ack_exclusive", 32'(both_seen), 0);
        chk("en_not_b2b", 32'(b2b_seen), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
